// File: rtl/writeback_queue.sv
// writeback_queue
// Buffers register-file writes coming out of the memory stage and drains them
// in order, one per cycle, to the scalar and vector register-file write ports.
//
// Ports
//   I_CLOCK, I_RESET        clock; synchronous active-high reset
//   I_LOCK, I_Kill          instruction valid / squash for this cycle
//   I_Opcode, I_DestRegIdx  instruction class and destination register
//   I_ALUOut, I_MemOut      scalar result sources (ALU ops / loads)
//   I_VALUOut, I_LaneMask   vector result (lane0 in LSBs) and compress-move lane enables
//   I_RFStall               register file cannot take a write this cycle
//   I_LookupIdx             decode-stage register to check for in-flight writes
//   O_Ready                 queue has room (independent of I_RFStall)
//   O_WriteBackEnable/RegIdx/Data            scalar write port (RegIdx shared)
//   O_VWriteBackEnable/VWriteBackMask/Data   vector write port
//   O_PendingHit, O_VPendingHit              queued scalar / vector write to I_LookupIdx
//   O_Overflow              sticky: a write arrived while the queue was full
//
// Handshake: an entry is accepted when it is a writing instruction
// (I_LOCK && !I_Kill) and O_Ready is high; the head is consumed whenever it is
// valid and I_RFStall is low, and the corresponding strobe is asserted in that
// same cycle. There is no bypass from input to output.

module writeback_queue #(
  parameter int REG_WIDTH    = 16,
  parameter int VLANES       = 4,
  parameter int IDX_WIDTH    = 6,
  parameter int OPCODE_WIDTH = 8,
  parameter int DEPTH        = 4
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_LOCK,
  input  logic                        I_Kill,
  input  logic [OPCODE_WIDTH-1:0]     I_Opcode,
  input  logic [IDX_WIDTH-1:0]        I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]        I_ALUOut,
  input  logic [REG_WIDTH-1:0]        I_MemOut,
  input  logic [VLANES*REG_WIDTH-1:0] I_VALUOut,
  input  logic [VLANES-1:0]           I_LaneMask,
  input  logic                        I_RFStall,
  input  logic [IDX_WIDTH-1:0]        I_LookupIdx,
  output logic                        O_Ready,
  output logic                        O_WriteBackEnable,
  output logic [IDX_WIDTH-1:0]        O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]        O_WriteBackData,
  output logic                        O_VWriteBackEnable,
  output logic [VLANES-1:0]           O_VWriteBackMask,
  output logic [VLANES*REG_WIDTH-1:0] O_VWriteBackData,
  output logic                        O_PendingHit,
  output logic                        O_VPendingHit,
  output logic                        O_Overflow
);

  localparam int VW    = VLANES * REG_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Opcode encodings shared with the rest of the pipeline.
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D     = OPCODE_WIDTH'('h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D    = OPCODE_WIDTH'('h01);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND_D     = OPCODE_WIDTH'('h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D    = OPCODE_WIDTH'('h03);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV       = OPCODE_WIDTH'('h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D    = OPCODE_WIDTH'('h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW       = OPCODE_WIDTH'('h06);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB       = OPCODE_WIDTH'('h07);
  localparam logic [OPCODE_WIDTH-1:0] OP_VADD      = OPCODE_WIDTH'('h20);
  localparam logic [OPCODE_WIDTH-1:0] OP_VMOV      = OPCODE_WIDTH'('h21);
  localparam logic [OPCODE_WIDTH-1:0] OP_VMOVI     = OPCODE_WIDTH'('h22);
  localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOV  = OPCODE_WIDTH'('h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOVI = OPCODE_WIDTH'('h24);

  // Queue storage; only the control state is reset, payloads are don't-care
  // until their valid bit is set.
  logic                 entValid [DEPTH];
  logic                 entVec   [DEPTH];
  logic [IDX_WIDTH-1:0] entIdx   [DEPTH];
  logic [VW-1:0]        entData  [DEPTH];
  logic [VLANES-1:0]    entMask  [DEPTH];
  logic [PTR_W-1:0]     headPtr, tailPtr;
  logic [CNT_W-1:0]     count;
  logic                 overflow;

  logic              isScalar, isVec, useMem, useLaneMask;
  logic [VLANES-1:0] pushMask;
  logic [VW-1:0]     pushData;
  logic              pushAttempt, full, doPush, headValid, doPop;

  always_comb begin
    isScalar    = 1'b0;
    isVec       = 1'b0;
    useMem      = 1'b0;
    useLaneMask = 1'b0;
    case (I_Opcode)
      OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV, OP_MOVI_D: isScalar = 1'b1;
      OP_LDW, OP_LDB: begin
        isScalar = 1'b1;
        useMem   = 1'b1;
      end
      OP_VADD, OP_VMOV, OP_VMOVI: isVec = 1'b1;
      OP_VCOMPMOV, OP_VCOMPMOVI: begin
        isVec       = 1'b1;
        useLaneMask = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pushMask    = useLaneMask ? I_LaneMask : '1;
    pushData    = isVec ? I_VALUOut : VW'(useMem ? I_MemOut : I_ALUOut);
    // A vector write that enables no lane has no effect, so it never occupies a slot.
    pushAttempt = I_LOCK && !I_Kill && (isScalar || (isVec && (|pushMask)));
    full        = (count == FULL_CNT);
    doPush      = pushAttempt && !full && !I_RESET;
    headValid   = entValid[headPtr];
    doPop       = headValid && !I_RFStall && !I_RESET;
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entValid[i] <= 1'b0;
    end else begin
      // Head and tail only coincide when empty (no pop) or full (no push),
      // so the two valid-bit updates never target the same slot.
      if (doPush) begin
        entValid[tailPtr] <= 1'b1;
        entVec[tailPtr]   <= isVec;
        entIdx[tailPtr]   <= I_DestRegIdx;
        entData[tailPtr]  <= pushData;
        entMask[tailPtr]  <= isVec ? pushMask : '0;
        tailPtr           <= tailPtr + PTR_ONE;
      end
      if (doPop) begin
        entValid[headPtr] <= 1'b0;
        headPtr           <= headPtr + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      if (pushAttempt && full) overflow <= 1'b1;
    end
  end

  always_comb begin
    O_Ready            = !full;
    O_Overflow         = overflow;
    O_WriteBackEnable  = doPop && !entVec[headPtr];
    O_VWriteBackEnable = doPop && entVec[headPtr];
    O_WriteBackRegIdx  = doPop ? entIdx[headPtr] : '0;
    O_WriteBackData    = O_WriteBackEnable ? entData[headPtr][REG_WIDTH-1:0] : '0;
    O_VWriteBackMask   = O_VWriteBackEnable ? entMask[headPtr] : '0;
    O_VWriteBackData   = O_VWriteBackEnable ? entData[headPtr] : '0;
    O_PendingHit       = 1'b0;
    O_VPendingHit      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entValid[i] && entIdx[i] == I_LookupIdx) begin
        if (entVec[i]) O_VPendingHit = 1'b1;
        else           O_PendingHit  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

  localparam int DEPTH = 4;

  localparam logic [7:0] ADD_D = 8'h00, ADDI_D = 8'h01, AND_D = 8'h02, ANDI_D = 8'h03;
  localparam logic [7:0] MOV = 8'h04, MOVI_D = 8'h05, LDW = 8'h06, LDB = 8'h07;
  localparam logic [7:0] STW = 8'h08, JMP = 8'h09, JSR = 8'h0A, JSRR = 8'h0B;
  localparam logic [7:0] BRN = 8'h0C, BRZ = 8'h0D, BRP = 8'h0E;
  localparam logic [7:0] VADD = 8'h20, VMOV = 8'h21, VMOVI = 8'h22;
  localparam logic [7:0] VCOMPMOV = 8'h23, VCOMPMOVI = 8'h24;

  logic        clk = 1'b0;
  logic        rst, lock, kill, stall;
  logic [7:0]  op;
  logic [5:0]  idx, lookIdx;
  logic [15:0] alu, mem;
  logic [63:0] valu;
  logic [3:0]  laneMask;
  logic        ready, wbEn, vEn, pHit, vpHit, ovf;
  logic [5:0]  wbIdx;
  logic [15:0] wbData;
  logic [3:0]  vMask;
  logic [63:0] vData;

  writeback_queue dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_Kill(kill), .I_Opcode(op),
    .I_DestRegIdx(idx), .I_ALUOut(alu), .I_MemOut(mem), .I_VALUOut(valu),
    .I_LaneMask(laneMask), .I_RFStall(stall), .I_LookupIdx(lookIdx),
    .O_Ready(ready), .O_WriteBackEnable(wbEn), .O_WriteBackRegIdx(wbIdx),
    .O_WriteBackData(wbData), .O_VWriteBackEnable(vEn), .O_VWriteBackMask(vMask),
    .O_VWriteBackData(vData), .O_PendingHit(pHit), .O_VPendingHit(vpHit),
    .O_Overflow(ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry packing: {isVec, idx[5:0], mask[3:0], data[63:0]}
  logic [74:0] exp_q[$];
  logic        expOvf = 1'b0;
  bit          checkOn = 1'b0;
  int          nChecks = 0;
  int          nFail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // 0 = no write, 1 = scalar ALU, 2 = scalar load, 3 = vector all lanes, 4 = vector masked
  function automatic int classOf(input logic [7:0] o);
    if (o inside {ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D}) return 1;
    if (o inside {LDW, LDB}) return 2;
    if (o inside {VADD, VMOV, VMOVI}) return 3;
    if (o inside {VCOMPMOV, VCOMPMOVI}) return 4;
    return 0;
  endfunction

  // Model state advances on each rising edge from the inputs held over the cycle.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      expOvf = 1'b0;
    end else begin
      int c;
      bit wasFull;
      bit attempt;
      logic [3:0] m;
      logic [74:0] e;
      c = classOf(op);
      m = (c == 4) ? laneMask : ((c == 3) ? 4'hF : 4'h0);
      attempt = lock && !kill && (c == 1 || c == 2 || (c >= 3 && m != 4'h0));
      wasFull = (exp_q.size() == DEPTH);
      if (exp_q.size() > 0 && !stall) void'(exp_q.pop_front());
      if (attempt) begin
        if (wasFull) expOvf = 1'b1;
        else begin
          if (c >= 3) e = {1'b1, idx, m, valu};
          else        e = {1'b0, idx, 4'h0, 48'h0, (c == 2) ? mem : alu};
          exp_q.push_back(e);
        end
      end
    end
  end

  // One compare per cycle, on the falling edge.
  always @(negedge clk) begin
    if (checkOn) begin
      bit en, hv, hs;
      logic [74:0] h;
      en = (exp_q.size() > 0) && !stall && !rst;
      h  = (exp_q.size() > 0) ? exp_q[0] : '0;
      hs = 1'b0;
      hv = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i][73:68] == lookIdx) begin
          if (exp_q[i][74]) hv = 1'b1;
          else              hs = 1'b1;
        end
      end
      chk("ready",   64'(ready),  64'(exp_q.size() < DEPTH));
      chk("wbEn",    64'(wbEn),   64'(en && !h[74]));
      chk("vEn",     64'(vEn),    64'(en && h[74]));
      chk("wbIdx",   64'(wbIdx),  en ? 64'(h[73:68]) : 64'h0);
      chk("wbData",  64'(wbData), (en && !h[74]) ? 64'(h[15:0]) : 64'h0);
      chk("vMask",   64'(vMask),  (en && h[74]) ? 64'(h[67:64]) : 64'h0);
      chk("vData",   vData,       (en && h[74]) ? h[63:0] : 64'h0);
      chk("pending", 64'(pHit),   64'(hs));
      chk("vpending",64'(vpHit),  64'(hv));
      chk("overflow",64'(ovf),    64'(expOvf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st);
    lock = 1'b0; kill = 1'b0; op = 8'hFF; idx = '0; alu = '0; mem = '0;
    valu = '0; laneMask = '0; stall = st;
  endtask

  task automatic drive(input logic [7:0] o, input logic [5:0] d, input logic [15:0] a,
                       input logic [15:0] mm, input logic [63:0] v, input logic [3:0] lm,
                       input logic st);
    lock = 1'b1; kill = 1'b0; op = o; idx = d; alu = a; mem = mm;
    valu = v; laneMask = lm; stall = st;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] opList[20];
    opList = '{ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D, LDW, LDB, STW, JMP,
               JSR, JSRR, BRN, BRZ, BRP, VADD, VMOV, VMOVI, VCOMPMOV, VCOMPMOVI};
    rst = 1'b1; lookIdx = '0;
    idle(1'b0);
    step(); step();
    rst = 1'b0;
    checkOn = 1'b1;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_wbEn",  64'(wbEn),  64'd0);
    chk("rst_ovf",   64'(ovf),   64'd0);

    // T1: single scalar ALU write, one-cycle latency, no bypass
    step(); drive(ADD_D, 6'd3, 16'h1234, 16'h0, 64'h0, 4'h0, 1'b0); #1;
    chk("t1_nobypass", 64'(wbEn), 64'd0);
    step(); idle(1'b0); #1;
    chk("t1_en",   64'(wbEn),   64'd1);
    chk("t1_idx",  64'(wbIdx),  64'd3);
    chk("t1_data", 64'(wbData), 64'h1234);
    step(); #1;
    chk("t1_idle_en",   64'(wbEn),   64'd0);
    chk("t1_idle_data", 64'(wbData), 64'd0);

    // T2: fill under stall, overflow, then strict FIFO drain
    for (int k = 1; k <= 4; k++) begin
      step(); drive(LDW, 6'(k), 16'h0, 16'(k), 64'h0, 4'h0, 1'b1);
    end
    step(); drive(LDW, 6'd9, 16'h0, 16'd5, 64'h0, 4'h0, 1'b1); #1;
    chk("t2_full_ready", 64'(ready), 64'd0);
    chk("t2_ovf_before", 64'(ovf),   64'd0);
    step(); idle(1'b1); #1;
    chk("t2_ovf_after", 64'(ovf), 64'd1);
    step(); idle(1'b0); #1;
    chk("t2_data1", 64'(wbData), 64'd1);
    for (int k = 2; k <= 4; k++) begin
      step(); #1;
      chk("t2_drain", 64'(wbData), 64'(k));
    end
    step(); #1;
    chk("t2_empty_en", 64'(wbEn), 64'd0);

    // T3: masked, empty-mask and full-mask vector writes
    step(); drive(VCOMPMOVI, 6'd2, 16'h0, 16'h0, 64'h1111_2222_3333_4444, 4'b0101, 1'b0);
    step(); drive(VCOMPMOVI, 6'd4, 16'h0, 16'h0, 64'h5, 4'b0000, 1'b0); #1;
    chk("t3_ven",  64'(vEn),   64'd1);
    chk("t3_mask", 64'(vMask), 64'b0101);
    chk("t3_idx",  64'(wbIdx), 64'd2);
    chk("t3_data", vData,      64'h1111_2222_3333_4444);
    step(); drive(VADD, 6'd7, 16'h0, 16'h0, 64'hABCD, 4'b0000, 1'b0); #1;
    chk("t3_zero_mask_dropped", 64'(vEn), 64'd0);
    step(); idle(1'b0); #1;
    chk("t3_vadd_mask", 64'(vMask), 64'hF);
    chk("t3_vadd_idx",  64'(wbIdx), 64'd7);

    // T4: pending lookups
    step(); drive(ADD_D, 6'd5, 16'h55, 16'h0, 64'h0, 4'h0, 1'b1);
    step(); drive(VMOV, 6'd5, 16'h0, 16'h0, 64'h77, 4'h0, 1'b1);
    step(); idle(1'b1); lookIdx = 6'd5; #1;
    chk("t4_hit",  64'(pHit),  64'd1);
    chk("t4_vhit", 64'(vpHit), 64'd1);
    lookIdx = 6'd6; #1;
    chk("t4_miss",  64'(pHit),  64'd0);
    chk("t4_vmiss", 64'(vpHit), 64'd0);
    step(); idle(1'b0);
    step(); step();

    // T5: non-writing and killed instructions are never queued
    step(); drive(STW, 6'd1, 16'h1, 16'h1, 64'h1, 4'hF, 1'b0);
    step(); drive(BRZ, 6'd1, 16'h1, 16'h1, 64'h1, 4'hF, 1'b0); #1;
    chk("t5_stw", 64'(wbEn | vEn), 64'd0);
    step(); drive(JSRR, 6'd1, 16'h1, 16'h1, 64'h1, 4'hF, 1'b0); #1;
    chk("t5_brz", 64'(wbEn | vEn), 64'd0);
    step(); drive(ADD_D, 6'd1, 16'h1, 16'h1, 64'h1, 4'hF, 1'b0); kill = 1'b1; #1;
    chk("t5_jsrr", 64'(wbEn | vEn), 64'd0);
    step(); idle(1'b0); #1;
    chk("t5_kill", 64'(wbEn | vEn), 64'd0);

    // T6: reset with three entries pending
    for (int k = 0; k < 3; k++) begin
      step(); drive(ADD_D, 6'd9, 16'(k), 16'h0, 64'h0, 4'h0, 1'b1);
    end
    step(); idle(1'b0); rst = 1'b1; lookIdx = 6'd9; #1;
    chk("t6_no_strobe_in_reset", 64'(wbEn), 64'd0);
    step(); rst = 1'b0; #1;
    chk("t6_ready", 64'(ready), 64'd1);
    chk("t6_wbEn",  64'(wbEn),  64'd0);
    chk("t6_vEn",   64'(vEn),   64'd0);
    chk("t6_ovf",   64'(ovf),   64'd0);
    chk("t6_hit",   64'(pHit),  64'd0);

    // Randomized traffic checked by the scoreboard every cycle
    for (int n = 0; n < 3000; n++) begin
      step();
      lock     = ($urandom_range(0, 9) < 8);
      kill     = ($urandom_range(0, 9) == 0);
      op       = ($urandom_range(0, 9) == 0) ? 8'($urandom) : opList[$urandom_range(0, 19)];
      idx      = 6'($urandom_range(0, 7));
      alu      = 16'($urandom);
      mem      = 16'($urandom);
      valu     = {$urandom, $urandom};
      laneMask = 4'($urandom);
      stall    = ($urandom_range(0, 9) < 4);
      lookIdx  = 6'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 99) == 0);
    end
    step(); rst = 1'b0; idle(1'b0);
    step(); step();
    checkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
